mem_lsu: RTL and testbench

//  Parametrised load/store unit for the MEM stage of the 5-stage RV32I core; replaces word-only dmem access.

---
 rtl/mem_lsu_pkg.sv | 20 ++
 rtl/mem_lsu_align.sv | 58 +++++
 rtl/mem_lsu.sv | 176 +++++++++++++++++
 tb/tb_mem_lsu.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 access codes,
// FSM state encoding and a funct3 legality helper.
package mem_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        LSU_IDLE = 1'b0,
        LSU_WAIT = 1'b1
    } lsu_state_e;

    function automatic logic f3_illegal(input logic [2:0] f3);
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Combinational byte-lane steering for the LSU: store byte enables and shifted
// write data, load lane select with sign/zero extension, misalignment detection.
module mem_lsu_align
    import mem_lsu_pkg::*;
#(
    parameter int FAULT_EN = 1
) (
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic        o_fault,
    output logic [3:0]  o_be,
    output logic [31:0] o_wword,
    output logic [31:0] o_rdata
);

    logic [1:0]  w_off;
    logic        w_mis;
    logic [31:0] w_rsh;

    // Offset is forced to natural alignment; with faults enabled a misaligned
    // request is flagged and the caller discards the steered result.
    always_comb begin
        w_off = 2'b00;
        w_mis = 1'b0;
        o_be  = 4'b1111;
        case (i_funct3)
            F3_B, F3_BU: begin
                w_off = i_off;
                o_be  = 4'b0001 << w_off;
            end
            F3_H, F3_HU: begin
                w_mis = i_off[0];
                w_off = {i_off[1], 1'b0};
                o_be  = 4'b0011 << w_off;
            end
            default: begin
                w_mis = (i_off != 2'b00);
                w_off = 2'b00;
                o_be  = 4'b1111;
            end
        endcase

        o_fault = (FAULT_EN != 0) && (w_mis || f3_illegal(i_funct3));
        o_wword = i_wdata << {w_off, 3'b000};
        w_rsh   = i_rword >> {w_off, 3'b000};

        case (i_funct3)
            F3_B:    o_rdata = {{24{w_rsh[7]}}, w_rsh[7:0]};
            F3_BU:   o_rdata = {24'h000000, w_rsh[7:0]};
            F3_H:    o_rdata = {{16{w_rsh[15]}}, w_rsh[15:0]};
            F3_HU:   o_rdata = {16'h0000, w_rsh[15:0]};
            default: o_rdata = w_rsh;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: byte-addressed data memory, wait-state FSM with
// pipeline stall, misalignment faults and the MEM/WB write-back register.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int DMEM_SIZE = 4096,
    parameter int LATENCY   = 0,
    parameter int FAULT_EN  = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_mem_read,
    input  logic        req_mem_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        req_reg_write,
    input  logic [4:0]  req_rd_addr,
    input  logic        req_link,
    input  logic [31:0] req_pc,
    output logic        stall,
    output logic [4:0]  wb_rd_addr,
    output logic [31:0] wb_data,
    output logic        fault,
    output logic [31:0] fault_addr
);

    localparam int AW = $clog2(DMEM_SIZE);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'((LATENCY > 0) ? LATENCY - 1 : 0);

    logic [7:0]    r_mem [DMEM_SIZE];
    lsu_state_e    r_state;
    logic [CW-1:0] r_cnt;
    logic [4:0]    r_wb_rd_addr;
    logic [31:0]   r_wb_data;
    logic          r_fault;
    logic [31:0]   r_fault_addr;

    logic [AW-1:0] w_idx;
    logic [AW-1:0] w_lane_idx [4];
    logic [31:0]   w_rword;
    logic [3:0]    w_be;
    logic [31:0]   w_wword;
    logic [31:0]   w_ldata;
    logic          w_align_fault;
    logic          w_is_mem;
    logic          w_is_store;
    logic          w_fault;
    logic          w_go;
    logic          w_complete;
    logic          w_stall;
    logic [4:0]    w_wb_rd_addr;
    logic [31:0]   w_wb_data;

    assign w_idx = req_addr[AW-1:0];

    // Byte lanes of the aligned word holding the access; upper address bits wrap.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_lane_idx[i]     = {w_idx[AW-1:2], 2'(i)};
            w_rword[8*i +: 8] = r_mem[w_lane_idx[i]];
        end
    end

    mem_lsu_align #(
        .FAULT_EN (FAULT_EN)
    ) u_align (
        .i_funct3 (req_funct3),
        .i_off    (req_addr[1:0]),
        .i_wdata  (req_wdata),
        .i_rword  (w_rword),
        .o_fault  (w_align_fault),
        .o_be     (w_be),
        .o_wword  (w_wword),
        .o_rdata  (w_ldata)
    );

    // Request decode and stall; load+store together behaves as a load.
    always_comb begin
        w_is_mem   = req_valid && (req_mem_read || req_mem_write);
        w_is_store = w_is_mem && req_mem_write && !req_mem_read;
        w_fault    = w_is_mem && w_align_fault;
        w_go       = w_is_mem && !w_align_fault;
        if (r_state == LSU_WAIT) begin
            w_complete = w_go && (r_cnt == '0);
            w_stall    = (r_cnt != '0);
        end else begin
            w_complete = w_go && (LATENCY == 0);
            w_stall    = w_go && (LATENCY != 0);
        end
    end

    // Write-back value for an instruction that completes on this edge.
    always_comb begin
        if (!req_valid || !req_reg_write || w_fault) begin
            w_wb_rd_addr = 5'd0;
            w_wb_data    = 32'd0;
        end else if (w_is_mem && req_mem_read) begin
            w_wb_rd_addr = req_rd_addr;
            w_wb_data    = w_ldata;
        end else if (req_link) begin
            w_wb_rd_addr = req_rd_addr;
            w_wb_data    = req_pc + 32'd4;
        end else begin
            w_wb_rd_addr = req_rd_addr;
            w_wb_data    = req_addr;
        end
    end

    // Store commit on the completing edge only; a reset on that edge drops it.
    always_ff @(posedge clock) begin
        if (!reset && w_complete && w_is_store) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_lane_idx[i]] <= w_wword[8*i +: 8];
                end
            end
        end
    end

    // Wait-state FSM, fault capture and MEM/WB register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= LSU_IDLE;
            r_cnt        <= '0;
            r_wb_rd_addr <= 5'd0;
            r_wb_data    <= 32'd0;
            r_fault      <= 1'b0;
            r_fault_addr <= 32'd0;
        end else begin
            r_fault <= w_fault;
            if (w_fault) begin
                r_fault_addr <= req_addr;
            end
            case (r_state)
                LSU_IDLE: begin
                    if (w_go && (LATENCY != 0)) begin
                        r_state      <= LSU_WAIT;
                        r_cnt        <= CNT_INIT;
                        r_wb_rd_addr <= 5'd0;
                        r_wb_data    <= 32'd0;
                    end else begin
                        r_wb_rd_addr <= w_wb_rd_addr;
                        r_wb_data    <= w_wb_data;
                    end
                end
                LSU_WAIT: begin
                    if (r_cnt != '0) begin
                        r_cnt        <= r_cnt - CW'(1);
                        r_wb_rd_addr <= 5'd0;
                        r_wb_data    <= 32'd0;
                    end else begin
                        r_state      <= LSU_IDLE;
                        r_wb_rd_addr <= w_wb_rd_addr;
                        r_wb_data    <= w_wb_data;
                    end
                end
                default: begin
                    r_state      <= LSU_IDLE;
                    r_cnt        <= '0;
                    r_wb_rd_addr <= 5'd0;
                    r_wb_data    <= 32'd0;
                end
            endcase
        end
    end

    assign stall      = w_stall;
    assign wb_rd_addr = r_wb_rd_addr;
    assign wb_data    = r_wb_data;
    assign fault      = r_fault;
    assign fault_addr = r_fault_addr;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed scoreboard bench for mem_lsu: one single-cycle instance and one
// instance with two wait states, each driven by its own request bundle.
module tb_mem_lsu;

    typedef struct packed {
        logic        valid;
        logic        rd_en;
        logic        wr_en;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rw;
        logic [4:0]  rd;
        logic        link;
        logic [31:0] pc;
    } req_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        flt;
        int          stalls;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    req_t        req_s [2];
    logic        stall_o [2];
    logic [4:0]  wb_rd_o [2];
    logic [31:0] wb_data_o [2];
    logic        fault_o [2];
    logic [31:0] fault_addr_o [2];

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb_q[$];
    logic [7:0] exp_bytes [4];

    always #5 clk = ~clk;

    mem_lsu #(.DMEM_SIZE(4096), .LATENCY(0), .FAULT_EN(1)) u_dut0 (
        .clock(clk), .reset(rst),
        .req_valid(req_s[0].valid), .req_mem_read(req_s[0].rd_en), .req_mem_write(req_s[0].wr_en),
        .req_funct3(req_s[0].f3), .req_addr(req_s[0].addr), .req_wdata(req_s[0].wdata),
        .req_reg_write(req_s[0].rw), .req_rd_addr(req_s[0].rd), .req_link(req_s[0].link), .req_pc(req_s[0].pc),
        .stall(stall_o[0]), .wb_rd_addr(wb_rd_o[0]), .wb_data(wb_data_o[0]),
        .fault(fault_o[0]), .fault_addr(fault_addr_o[0])
    );

    mem_lsu #(.DMEM_SIZE(4096), .LATENCY(2), .FAULT_EN(1)) u_dut2 (
        .clock(clk), .reset(rst),
        .req_valid(req_s[1].valid), .req_mem_read(req_s[1].rd_en), .req_mem_write(req_s[1].wr_en),
        .req_funct3(req_s[1].f3), .req_addr(req_s[1].addr), .req_wdata(req_s[1].wdata),
        .req_reg_write(req_s[1].rw), .req_rd_addr(req_s[1].rd), .req_link(req_s[1].link), .req_pc(req_s[1].pc),
        .stall(stall_o[1]), .wb_rd_addr(wb_rd_o[1]), .wb_data(wb_data_o[1]),
        .fault(fault_o[1]), .fault_addr(fault_addr_o[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp_v);
        end
    endtask

    function automatic req_t ld(input logic [2:0] f3, input logic [31:0] a, input logic [4:0] rd);
        ld = '0;
        ld.valid = 1'b1; ld.rd_en = 1'b1; ld.f3 = f3; ld.addr = a; ld.rw = 1'b1; ld.rd = rd;
    endfunction

    function automatic req_t st(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        st = '0;
        st.valid = 1'b1; st.wr_en = 1'b1; st.f3 = f3; st.addr = a; st.wdata = wd;
    endfunction

    function automatic req_t alu(input logic v, input logic [31:0] a, input logic rw,
                                 input logic [4:0] rd, input logic lk, input logic [31:0] pc);
        alu = '0;
        alu.valid = v; alu.addr = a; alu.rw = rw; alu.rd = rd; alu.link = lk; alu.pc = pc;
    endfunction

    // Called at a negative edge: drive, count stall cycles, then check the write-back.
    task automatic do_op(input int d, input req_t r, input logic [4:0] e_rd, input logic [31:0] e_data,
                         input logic e_flt, input int e_stalls, input string tag);
        exp_t e;
        int   n;
        req_s[d] = r;
        sb_q.push_back('{rd: e_rd, data: e_data, flt: e_flt, stalls: e_stalls});
        #1;
        n = 0;
        while (stall_o[d] === 1'b1 && n < 8) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            chk({tag, "/bubble_rd"}, {27'd0, wb_rd_o[d]}, 32'd0);
        end
        @(posedge clk);
        @(negedge clk);
        e = sb_q.pop_front();
        chk({tag, "/stalls"}, n, e.stalls);
        chk({tag, "/rd"}, {27'd0, wb_rd_o[d]}, {27'd0, e.rd});
        chk({tag, "/data"}, wb_data_o[d], e.data);
        chk({tag, "/fault"}, {31'd0, fault_o[d]}, {31'd0, e.flt});
        if (e.flt) begin
            chk({tag, "/fault_addr"}, fault_addr_o[d], r.addr);
        end
    endtask

    initial begin
        req_t r;
        exp_bytes[0] = 8'hEF; exp_bytes[1] = 8'hBE; exp_bytes[2] = 8'hAD; exp_bytes[3] = 8'hDE;
        rst = 1'b1;
        req_s[0] = '0;
        req_s[1] = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset%0d/rd", d), {27'd0, wb_rd_o[d]}, 32'd0);
            chk($sformatf("reset%0d/data", d), wb_data_o[d], 32'd0);
            chk($sformatf("reset%0d/fault", d), {31'd0, fault_o[d]}, 32'd0);
            chk($sformatf("reset%0d/fault_addr", d), fault_addr_o[d], 32'd0);
            chk($sformatf("reset%0d/stall", d), {31'd0, stall_o[d]}, 32'd0);
        end
        rst = 1'b0;

        // Single-cycle instance: lane steering and extension
        do_op(0, st(3'b010, 32'h100, 32'hDEADBEEF), 5'd0, 32'd0, 1'b0, 0, "sw_100");
        do_op(0, ld(3'b010, 32'h100, 5'd5), 5'd5, 32'hDEADBEEF, 1'b0, 0, "lw_100");
        do_op(0, ld(3'b000, 32'h103, 5'd6), 5'd6, 32'hFFFFFFDE, 1'b0, 0, "lb_103");
        do_op(0, ld(3'b100, 32'h103, 5'd6), 5'd6, 32'h000000DE, 1'b0, 0, "lbu_103");
        do_op(0, ld(3'b001, 32'h102, 5'd7), 5'd7, 32'hFFFFDEAD, 1'b0, 0, "lh_102");
        do_op(0, ld(3'b101, 32'h100, 5'd7), 5'd7, 32'h0000BEEF, 1'b0, 0, "lhu_100");
        for (int i = 0; i < 4; i++) begin
            do_op(0, ld(3'b100, 32'h100 + i, 5'd8), 5'd8, {24'd0, exp_bytes[i]}, 1'b0, 0,
                  $sformatf("byte_%0d", i));
        end

        // Faults: misaligned SH/LW, illegal funct3; memory must be untouched
        do_op(0, st(3'b001, 32'h101, 32'h00001234), 5'd0, 32'd0, 1'b1, 0, "sh_mis");
        do_op(0, ld(3'b010, 32'h100, 5'd5), 5'd5, 32'hDEADBEEF, 1'b0, 0, "lw_after_mis");
        chk("fault_addr_sticky", fault_addr_o[0], 32'h101);
        do_op(0, ld(3'b010, 32'h101, 5'd7), 5'd0, 32'd0, 1'b1, 0, "lw_mis");
        do_op(0, ld(3'b011, 32'h100, 5'd8), 5'd0, 32'd0, 1'b1, 0, "ld_illegal");

        // Non-memory ops
        do_op(0, alu(1'b1, 32'h0, 1'b1, 5'd1, 1'b1, 32'h40), 5'd1, 32'h44, 1'b0, 0, "link");
        do_op(0, alu(1'b1, 32'h1234, 1'b1, 5'd2, 1'b0, 32'h40), 5'd2, 32'h1234, 1'b0, 0, "alu");
        do_op(0, alu(1'b1, 32'h1234, 1'b0, 5'd2, 1'b0, 32'h40), 5'd0, 32'd0, 1'b0, 0, "no_rw");
        do_op(0, alu(1'b0, 32'h55, 1'b1, 5'd3, 1'b0, 32'h40), 5'd0, 32'd0, 1'b0, 0, "bubble");

        // Address aliasing, partial stores, load+store conflict
        do_op(0, st(3'b010, 32'h1010, 32'hCAFEF00D), 5'd0, 32'd0, 1'b0, 0, "sw_alias");
        do_op(0, ld(3'b010, 32'h010, 5'd9), 5'd9, 32'hCAFEF00D, 1'b0, 0, "lw_alias");
        do_op(0, st(3'b000, 32'h102, 32'hFFFFFF77), 5'd0, 32'd0, 1'b0, 0, "sb_102");
        do_op(0, ld(3'b010, 32'h100, 5'd5), 5'd5, 32'hDE77BEEF, 1'b0, 0, "lw_after_sb");
        do_op(0, st(3'b001, 32'h102, 32'hFFFF5566), 5'd0, 32'd0, 1'b0, 0, "sh_102");
        do_op(0, ld(3'b010, 32'h100, 5'd5), 5'd5, 32'h5566BEEF, 1'b0, 0, "lw_after_sh");
        r = ld(3'b010, 32'h100, 5'd3);
        r.wr_en = 1'b1;
        r.wdata = 32'h0;
        do_op(0, r, 5'd3, 32'h5566BEEF, 1'b0, 0, "ld_st_both");
        do_op(0, ld(3'b010, 32'h100, 5'd3), 5'd3, 32'h5566BEEF, 1'b0, 0, "lw_after_both");
        req_s[0] = '0;

        // Two-wait-state instance
        do_op(1, st(3'b010, 32'h200, 32'h11223344), 5'd0, 32'd0, 1'b0, 2, "l2_sw");
        do_op(1, alu(1'b1, 32'h0, 1'b1, 5'd1, 1'b1, 32'h80), 5'd1, 32'h84, 1'b0, 0, "l2_link");
        do_op(1, ld(3'b010, 32'h200, 5'd4), 5'd4, 32'h11223344, 1'b0, 2, "l2_lw");
        do_op(1, ld(3'b100, 32'h201, 5'd4), 5'd4, 32'h00000033, 1'b0, 2, "l2_lbu");
        do_op(1, st(3'b010, 32'h202, 32'h0), 5'd0, 32'd0, 1'b1, 0, "l2_sw_mis");

        // Reset on the edge that would commit a waiting store
        req_s[1] = st(3'b010, 32'h200, 32'h99999999);
        #1;
        chk("l2_rst/stall0", {31'd0, stall_o[1]}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("l2_rst/stall1", {31'd0, stall_o[1]}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("l2_rst/stall2", {31'd0, stall_o[1]}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_s[1] = '0;
        rst = 1'b0;
        chk("l2_rst/fault_addr", fault_addr_o[1], 32'd0);
        chk("l2_rst/rd", {27'd0, wb_rd_o[1]}, 32'd0);
        chk("l2_rst/data", wb_data_o[1], 32'd0);
        do_op(1, ld(3'b010, 32'h200, 5'd4), 5'd4, 32'h11223344, 1'b0, 2, "l2_lw_after_rst");
        do_op(0, ld(3'b010, 32'h100, 5'd5), 5'd5, 32'h5566BEEF, 1'b0, 0, "lw_after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

endmodule
